// File: rtl/fractcam_pkg.sv
// Shared fractal-TCAM types: index-width helper and the priority-encoder result record.
package fractcam_pkg;

    localparam int RES_IDX_W = 32;

    typedef struct packed {
        logic [RES_IDX_W-1:0] idx;
        logic                 hit;
        logic                 multi;
    } prio_res_t;

    // Width of an index into n items; never below one bit so ports stay legal.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/match_prio_enc_if.sv
// Match-line input channel and encoded-result output channel of match_prio_enc.
interface match_prio_enc_if #(parameter int DEPTH = 64);
    import fractcam_pkg::*;

    localparam int IDX_W = idx_w(DEPTH);

    logic [DEPTH-1:0] match_in;
    logic             match_valid;
    logic             match_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_hit;
    logic             out_multi;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output match_in, match_valid, out_ready,
        input  match_ready, out_idx, out_hit, out_multi, out_valid
    );

    modport slave (
        input  match_in, match_valid, out_ready,
        output match_ready, out_idx, out_hit, out_multi, out_valid
    );

endinterface

// File: rtl/match_prio_enc_grp.sv
// Combinational first-stage encoder for one group of match lines: any hit, 2+ hits, lowest offset.
module prio_enc_grp
    import fractcam_pkg::*;
#(
    parameter  int GROUP = 8,
    localparam int OFF_W = idx_w(GROUP)
) (
    input  logic [GROUP-1:0] i_bits,
    output logic             o_hit,
    output logic             o_multi,
    output logic [OFF_W-1:0] o_off
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        o_off = '0;
        for (int i = GROUP - 1; i >= 0; i--) begin
            if (i_bits[i]) o_off = OFF_W'(i);
        end
    end

    assign o_hit   = |i_bits;
    assign o_multi = (i_bits & (i_bits - GROUP'(1))) != '0;

endmodule

// File: rtl/match_prio_enc.sv
// Two-stage TCAM match-line priority encoder (entry 0 wins) with valid/ready on both sides.
// Optional saturating hit/miss result counters are built when PRIO_ENC_STATS_EN is defined.
module match_prio_enc
    import fractcam_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int GROUP = 8
) (
    input  logic             clk,
    input  logic             rst,
    match_prio_enc_if.slave  bus
`ifdef PRIO_ENC_STATS_EN
    ,
    output logic [31:0]      hit_cnt,
    output logic [31:0]      miss_cnt
`endif
);

    localparam int IDX_W = idx_w(DEPTH);
    localparam int NGRP  = DEPTH / GROUP;
    localparam int OFF_W = idx_w(GROUP);
    localparam int GRP_W = idx_w(NGRP);

    logic [NGRP-1:0]  w_grp_hit;
    logic [NGRP-1:0]  w_grp_multi;
    logic [OFF_W-1:0] w_grp_off [NGRP];

    logic [NGRP-1:0]  r_grp_hit_p1;
    logic [NGRP-1:0]  r_grp_multi_p1;
    logic [OFF_W-1:0] r_grp_off_p1 [NGRP];
    logic             r_vld_p1;

    prio_res_t        w_res;
    logic [GRP_W-1:0] w_sel;
    prio_res_t        r_res_p2;
    logic             r_vld_p2;

    logic             w_rdy_p1;
    logic             w_rdy_p2;
    logic             w_unused_idx;

    assign w_rdy_p2 = !r_vld_p2 || bus.out_ready;
    assign w_rdy_p1 = !r_vld_p1 || w_rdy_p2;

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        prio_enc_grp #(.GROUP(GROUP)) u_grp (
            .i_bits  (bus.match_in[g*GROUP +: GROUP]),
            .o_hit   (w_grp_hit[g]),
            .o_multi (w_grp_multi[g]),
            .o_off   (w_grp_off[g])
        );
    end

    // ---- stage 1: per-group summaries ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
        end else if (w_rdy_p1) begin
            r_vld_p1 <= bus.match_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rdy_p1 && bus.match_valid) begin
            r_grp_hit_p1   <= w_grp_hit;
            r_grp_multi_p1 <= w_grp_multi;
            r_grp_off_p1   <= w_grp_off;
        end
    end

    // ---- stage 2: pick the lowest hitting group ----
    always_comb begin
        w_sel = '0;
        w_res = '0;
        for (int g = NGRP - 1; g >= 0; g--) begin
            if (r_grp_hit_p1[g]) w_sel = GRP_W'(g);
        end
        w_res.idx   = RES_IDX_W'(w_sel) * RES_IDX_W'(GROUP) + RES_IDX_W'(r_grp_off_p1[w_sel]);
        w_res.hit   = |r_grp_hit_p1;
        w_res.multi = ((r_grp_hit_p1 & (r_grp_hit_p1 - NGRP'(1))) != '0) || r_grp_multi_p1[w_sel];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p2 <= 1'b0;
            r_res_p2 <= '0;
        end else if (w_rdy_p2) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) r_res_p2 <= w_res;
        end
    end

    assign bus.match_ready = w_rdy_p1;
    assign bus.out_valid   = r_vld_p2;
    assign bus.out_idx     = r_res_p2.idx[IDX_W-1:0];
    assign bus.out_hit     = r_res_p2.hit;
    assign bus.out_multi   = r_res_p2.multi;
    assign w_unused_idx    = ^r_res_p2.idx[RES_IDX_W-1:IDX_W];

`ifdef PRIO_ENC_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;
    logic        w_out_xfer;

    assign w_out_xfer = r_vld_p2 && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_out_xfer) begin
            if (r_res_p2.hit) begin
                if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
                if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_match_prio_enc.sv
// Randomized self-checking bench for match_prio_enc against a queue-based reference model.
module tb_match_prio_enc;

    localparam int DEPTH = 64;

    typedef struct packed {
        logic [5:0] idx;
        logic       hit;
        logic       multi;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    int   n_pop = 0;
    exp_t exp_q[$];

    logic       stall_pend = 1'b0;
    logic [5:0] sv_idx;
    logic       sv_hit;
    logic       sv_multi;

    match_prio_enc_if #(.DEPTH(DEPTH)) bus ();

`ifdef PRIO_ENC_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
    logic [31:0] m0;
`endif

    match_prio_enc #(.DEPTH(DEPTH), .GROUP(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef PRIO_ENC_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: lowest set bit, any bit set, and population count above one.
    function automatic exp_t model(input logic [63:0] v);
        exp_t e;
        e       = '0;
        e.hit   = (v != 64'd0);
        e.multi = ($countones(v) > 1);
        for (int i = 0; i < 64; i++) begin
            if (v[i]) begin
                e.idx = 6'(i);
                break;
            end
        end
        return e;
    endfunction

    function automatic logic [63:0] rand_vec();
        logic [63:0] v;
        case ($urandom_range(0, 3))
            0:       v = 64'd0;
            1:       v = 64'd1 << $urandom_range(0, 63);
            2:       v = {$urandom, $urandom};
            default: v = (64'd1 << $urandom_range(0, 63)) | (64'd1 << $urandom_range(0, 63));
        endcase
        return v;
    endfunction

    // Scoreboard: evaluates what the coming rising edge will transfer.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall_pend = 1'b0;
        end else begin
            chk("ready", bus.match_ready, !(exp_q.size() == 2 && !bus.out_ready));
            if (stall_pend) begin
                chk("hold.vld", bus.out_valid, 1);
                chk("hold.idx", bus.out_idx, sv_idx);
                chk("hold.hit", bus.out_hit, sv_hit);
                chk("hold.multi", bus.out_multi, sv_multi);
            end
            if (exp_q.size() == 0) begin
                chk("spurious", bus.out_valid, 0);
            end else if (bus.out_valid && bus.out_ready) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb.idx", bus.out_idx, e.idx);
                chk("sb.hit", bus.out_hit, e.hit);
                chk("sb.multi", bus.out_multi, e.multi);
                n_pop++;
            end
            stall_pend = bus.out_valid && !bus.out_ready;
            sv_idx     = bus.out_idx;
            sv_hit     = bus.out_hit;
            sv_multi   = bus.out_multi;
            if (bus.match_valid && bus.match_ready) exp_q.push_back(model(bus.match_in));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called one time unit after a rising edge with an empty pipeline and out_ready high.
    task automatic directed(input string tag, input logic [63:0] v, input int e_idx,
                            input logic e_hit, input logic e_multi);
        bus.match_valid = 1'b1;
        bus.match_in    = v;
        @(negedge clk);
        chk({tag, ".ready"}, bus.match_ready, 1);
        step();
        bus.match_valid = 1'b0;
        bus.match_in    = '0;
        @(negedge clk);
        chk({tag, ".lat1"}, bus.out_valid, 0);
        @(negedge clk);
        chk({tag, ".vld"}, bus.out_valid, 1);
        chk({tag, ".idx"}, bus.out_idx, 64'(e_idx));
        chk({tag, ".hit"}, bus.out_hit, e_hit);
        chk({tag, ".multi"}, bus.out_multi, e_multi);
    endtask

    task automatic drain();
        int cyc;
        cyc             = 0;
        bus.match_valid = 1'b0;
        bus.out_ready   = 1'b1;
        while (exp_q.size() != 0 && cyc < 20) begin
            step();
            cyc++;
        end
        @(negedge clk);
        #1;
        chk("drain", exp_q.size(), 0);
        step();
    endtask

    initial begin
        int sent;
        int acc;
        int base;
        bus.match_valid = 1'b0;
        bus.match_in    = '0;
        bus.out_ready   = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst.out_valid", bus.out_valid, 0);
        chk("rst.out_idx", bus.out_idx, 0);
        chk("rst.out_hit", bus.out_hit, 0);
        chk("rst.out_multi", bus.out_multi, 0);
        chk("rst.match_ready", bus.match_ready, 1);
`ifdef PRIO_ENC_STATS_EN
        chk("rst.hit_cnt", hit_cnt, 0);
        chk("rst.miss_cnt", miss_cnt, 0);
`endif

        step();
        rst = 1'b0;
        directed("single37", 64'd1 << 37, 37, 1'b1, 1'b0);
        step();
        directed("multi_5_9_63", (64'd1 << 5) | (64'd1 << 9) | (64'd1 << 63), 5, 1'b1, 1'b1);
        step();
        directed("multi_12_13", (64'd1 << 12) | (64'd1 << 13), 12, 1'b1, 1'b1);
        step();
`ifdef PRIO_ENC_STATS_EN
        m0 = miss_cnt;
`endif
        directed("miss", 64'd0, 0, 1'b0, 1'b0);
`ifdef PRIO_ENC_STATS_EN
        @(negedge clk);
        chk("miss_cnt.inc", miss_cnt, m0 + 32'd1);
        dut.r_hit_cnt <= 32'hFFFF_FFFE;
`endif
        step();
        directed("bit63", 64'd1 << 63, 63, 1'b1, 1'b0);
        step();
        directed("all_ones", {64{1'b1}}, 0, 1'b1, 1'b1);
`ifdef PRIO_ENC_STATS_EN
        @(negedge clk);
        chk("hit_cnt.sat", hit_cnt, 32'hFFFF_FFFF);
`endif
        step();

        // Back-to-back acceptance with the output always ready.
        acc = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.match_valid = 1'b1;
            bus.match_in    = 64'd1 << (40 + i);
            @(negedge clk);
            if (bus.match_ready) acc++;
            step();
        end
        chk("thru.accepted", acc, 8);
        drain();

        // Indices 0..9 streamed under random output backpressure.
        sent = 0;
        base = n_pop;
        for (int cyc = 0; cyc < 300 && sent < 10; cyc++) begin
            bus.match_valid = 1'b1;
            bus.match_in    = 64'd1 << sent;
            bus.out_ready   = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.match_ready) sent++;
            step();
        end
        bus.match_valid = 1'b0;
        chk("bp.sent", sent, 10);
        drain();
        chk("bp.count", n_pop - base, 10);

        // Two results in flight, then a one-cycle reset.
        bus.out_ready   = 1'b0;
        bus.match_valid = 1'b1;
        bus.match_in    = 64'd1 << 3;
        step();
        bus.match_in    = 64'd1 << 4;
        step();
        bus.match_valid = 1'b0;
        @(negedge clk);
        chk("rmf.full_ready", bus.match_ready, 0);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rmf.rst_vld", bus.out_valid, 0);
        chk("rmf.rst_ready", bus.match_ready, 1);
        chk("rmf.rst_idx", bus.out_idx, 0);
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rmf.idle", bus.out_valid, 0);
            step();
        end

        // Random traffic with random valid and backpressure.
        base = n_pop;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.match_valid = 1'($urandom_range(0, 1));
            bus.match_in    = rand_vec();
            bus.out_ready   = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();
        chk("rand.some_results", (n_pop - base) > 50, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/match_prio_enc.md
MATCH_PRIO_ENC -- requirements
Module: match_prio_enc

Interface
REQ-001 SHALL have parameter DEPTH, default 64: number of TCAM entries/match lines; power of two, >= 2.
REQ-002 SHALL have parameter GROUP, default 8: entries per first-stage group; power of two; DEPTH % GROUP == 0; GROUP <= DEPTH.
REQ-003 SHALL derive IDX_W = clog2(DEPTH) and NGRP = DEPTH/GROUP; neither is a port-overridable parameter.
REQ-004 SHALL use one clock and an asynchronous active-high reset: clk in 1 (all state on rising edge); rst in 1 (async assert, active-high).
REQ-005 SHALL have port match_in, in, DEPTH: per-entry match lines from the AND stage; bit i = entry i hit.
REQ-006 SHALL have ports match_valid, in, 1 (match_in valid) and match_ready, out, 1 (block accepts match_in).
REQ-007 SHALL have port out_idx, out, IDX_W: lowest-numbered matching entry; 0 on miss.
REQ-008 SHALL have ports out_hit, out, 1 (at least one bit set) and out_multi, out, 1 (two or more bits set).
REQ-009 SHALL have ports out_valid, out, 1 and out_ready, in, 1: result handshake.
REQ-010 SHALL, with PRIO_ENC_STATS_EN only, have ports hit_cnt, out, 32 and miss_cnt, out, 32: accepted-result counters.

Function
REQ-011 SHALL treat a transfer as occurring on a rising edge where valid && ready on the respective interface.
REQ-012 SHALL give entry 0 the highest priority.
REQ-013 SHALL use a two-stage pipeline. Stage 1 registers, per group g, grp_hit[g], grp_multi[g] (>=2 hits in group) and grp_off[g] (lowest hit offset, log2 GROUP bits). Stage 2 selects the lowest g with grp_hit set, then registers idx = g*GROUP + grp_off[g], hit, and multi = (two or more grp_hit set) OR grp_multi[g].
REQ-014 SHALL assert out_valid exactly 2 cycles after an accepted match_in when out_ready is held high.
REQ-015 SHALL sustain one accepted input per cycle when out_ready is held high.
REQ-016 SHALL set each stage's ready to (!stage_valid || next_ready); match_ready equals stage-1 ready.
REQ-017 SHALL hold out_idx, out_hit and out_multi stable while out_valid && !out_ready.
REQ-018 SHALL drop and reorder no results under any out_ready pattern; results leave in acceptance order.
REQ-019 SHALL NOT load registers for a cycle with match_valid low or all-zero data without valid.
REQ-020 SHALL output out_hit=0, out_multi=0, out_idx=0 for an all-zero match_in.
REQ-021 SHALL, on a simultaneous stage-1 drain and new accept, load the new input (no bubble).

Reset
REQ-022 SHALL, while rst is high, clear all valid flags. Values: out_valid=0, out_idx=0, out_hit=0, out_multi=0, match_ready=1.
REQ-023 SHALL discard in-flight data when reset is asserted mid-operation; no result is emitted for it after release.
REQ-024 SHALL accept input on the first edge after rst deasserts.

Configuration
REQ-025 SHALL, with macro PRIO_ENC_STATS_EN defined, count each output transfer: hit_cnt increments when out_hit=1, miss_cnt when out_hit=0. Both saturate at 0xFFFFFFFF. Both reset to 0.
REQ-026 SHALL, without PRIO_ENC_STATS_EN, omit hit_cnt, miss_cnt and their logic; other behaviour is identical.

Structure
REQ-027 SHALL take the index-width function and the result struct (idx, hit, multi) from shared package fractcam_pkg.
REQ-028 SHALL implement the per-group encoder as combinational sub-module prio_enc_grp: GROUP bits in; hit, multi and offset out. It is instantiated NGRP times.

Verification
REQ-029 SHALL be covered by a single-hit test: match_in = 1<<37, out_ready=1 -> 2 cycles later out_valid=1, out_idx=37, out_hit=1, out_multi=0.
REQ-030 SHALL be covered by a multi-hit test: bits 5, 9, 63 set -> out_idx=5, out_multi=1. Bits 12 and 13 (same group) set -> out_idx=12, out_multi=1.
REQ-031 SHALL be covered by a miss test: match_in = 0 -> out_hit=0, out_idx=0. With PRIO_ENC_STATS_EN, miss_cnt +1.
REQ-032 SHALL be covered by a backpressure test: stream indices 0..9 while out_ready toggles randomly -> 10 results in order, stable while stalled. match_ready is low only when both stages are full and out_ready=0.
REQ-033 SHALL be covered by a reset-mid-flight test: accept 2 inputs, assert rst for 1 cycle -> out_valid stays 0 and no stale result appears.
REQ-034 SHALL be covered by a boundary test: bit 63 only -> out_idx=63. All ones -> out_idx=0, out_multi=1. With PRIO_ENC_STATS_EN, hit_cnt is preloaded near saturation and stays at 0xFFFFFFFF.
